// File: rtl/uart_tx_sched.sv
// Round-robin byte scheduler feeding one 8N1 UART transmitter (8N2 when UART_TX_SCHED_STOP2_EN is defined).
// A grant is taken in IDLE on the accept edge; REQ_READY stays low while a frame is on the line.
module uart_tx_sched #(
  parameter int NUM_REQ   = 4,
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic                   CLOCK,
  input  logic                   RESET_N,
  input  logic [NUM_REQ-1:0]     REQ_VALID,
  input  logic [8*NUM_REQ-1:0]   REQ_DATA,
  output logic [NUM_REQ-1:0]     REQ_READY,
  output logic                   STX,
  output logic                   BUSY,
  output logic [1:0]             GRANT_ID
);

  localparam int DIVISOR = CLK_FREQ / BAUD_RATE;
`ifdef UART_TX_SCHED_STOP2_EN
  localparam int STOP_LEN = 2 * DIVISOR;
`else
  localparam int STOP_LEN = DIVISOR;
`endif
  localparam int CW = $clog2(2 * DIVISOR + 1);

  if (DIVISOR < 2) begin : g_div_chk
    $error("uart_tx_sched: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_req_chk
    $error("uart_tx_sched: NUM_REQ must be in 2..4");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [1:0]      last_q, last_d;
  logic [1:0]      gid_q, gid_d;
  logic            stx_q, stx_d;
  logic            busy_q, busy_d;

  logic            gnt_vld;
  logic [1:0]      gnt_idx;
  logic [7:0]      gnt_dat;

  // Rank each requester by its distance past last_q; the nearest valid one wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!gnt_vld && REQ_VALID[i] &&
            ((i + NUM_REQ - 1 - int'(last_q)) % NUM_REQ) == k) begin
          gnt_vld = 1'b1;
          gnt_idx = 2'(i);
        end
      end
    end
  end

  always_comb begin
    gnt_dat   = '0;
    REQ_READY = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == 2'(i)) gnt_dat = REQ_DATA[8*i +: 8];
      REQ_READY[i] = RESET_N && (state_q == IDLE) && gnt_vld && (gnt_idx == 2'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    last_d  = last_q;
    gid_d   = gid_q;
    stx_d   = stx_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          state_d = START;
          shreg_d = gnt_dat;
          last_d  = gnt_idx;
          gid_d   = gnt_idx;
          stx_d   = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = CW'(DIVISOR - 1);
        end
      end
      START: begin
        if (cnt_q == '0) begin
          state_d = DATA;
          stx_d   = shreg_q[0];
          bit_d   = '0;
          cnt_d   = CW'(DIVISOR - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            stx_d   = 1'b1;
            cnt_d   = CW'(STOP_LEN - 1);
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = shreg_q >> 1;
            stx_d   = shreg_q[1];
            cnt_d   = CW'(DIVISOR - 1);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      last_q  <= 2'(NUM_REQ - 1);
      gid_q   <= '0;
      stx_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      stx_q   <= stx_d;
      busy_q  <= busy_d;
    end
  end

  assign STX      = stx_q;
  assign BUSY     = busy_q;
  assign GRANT_ID = gid_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: decodes the serial line and checks grants, timing and reset abort.
module tb_uart_tx_sched;

`ifdef UART_TX_SCHED_STOP2_EN
  localparam int STOP_CYC = 20;
`else
  localparam int STOP_CYC = 10;
`endif
  localparam int BUSY_LEN = 90 + STOP_CYC;
  localparam int PERIOD   = 91 + STOP_CYC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        stx;
  logic        busy;
  logic [1:0]  grant_id;

  uart_tx_sched #(.NUM_REQ(4), .CLK_FREQ(1000000), .BAUD_RATE(100000)) dut (
    .CLOCK(clk), .RESET_N(rst_n), .REQ_VALID(req_valid), .REQ_DATA(req_data),
    .REQ_READY(req_ready), .STX(stx), .BUSY(busy), .GRANT_ID(grant_id)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Line decoder: samples on the falling edge, logs each completed frame.
  int         cyc = 0, pos = 0, st_cyc = 0, busy_run = 0;
  bit         in_frame = 0, bad = 0;
  logic       seg;
  logic [7:0] cur;
  logic [7:0] frm_byte[$];
  int         frm_cyc[$];
  bit         frm_bad[$];
  int         busy_q[$];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      in_frame = 0;
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      else if (busy_run != 0) begin
        busy_q.push_back(busy_run);
        busy_run = 0;
      end
      if (!in_frame) begin
        if (stx == 1'b0) begin
          in_frame = 1; pos = 0; bad = 0; cur = '0; st_cyc = cyc;
        end
      end else pos++;
      if (in_frame) begin
        if (pos % 10 == 0) seg = stx;
        else if (stx !== seg) bad = 1;
        if (pos < 10) begin
          if (stx !== 1'b0) bad = 1;
        end else if (pos < 90) begin
          if (pos % 10 == 5) cur[pos/10 - 1] = stx;
        end else if (stx !== 1'b1) bad = 1;
        if (pos == 89 + STOP_CYC) begin
          frm_byte.push_back(cur);
          frm_cyc.push_back(st_cyc);
          frm_bad.push_back(bad);
          in_frame = 0;
        end
      end
    end
  end

  int rem[4];
  int rdy_cnt[4];
  int glog[$];

  function automatic int frm_at(int k);
    return (k < frm_byte.size()) ? int'(frm_byte[k]) : -1;
  endfunction
  function automatic int cyc_at(int k);
    return (k < frm_cyc.size()) ? frm_cyc[k] : -1;
  endfunction
  function automatic int bad_at(int k);
    return (k < frm_bad.size()) ? int'(frm_bad[k]) : -1;
  endfunction
  function automatic int glog_at(int k);
    return (k < glog.size()) ? glog[k] : -1;
  endfunction
  function automatic int busy_at(int k);
    return (k < busy_q.size()) ? busy_q[k] : -1;
  endfunction

  // One cycle: observe accepts just before the edge, then retire satisfied requesters.
  task automatic tick();
    logic [3:0] xfer;
    #1;
    xfer = req_valid & req_ready & {4{rst_n}};
    for (int i = 0; i < 4; i++) begin
      rdy_cnt[i] += int'(req_ready[i]);
      if (xfer[i]) glog.push_back(i);
    end
    @(posedge clk);
    #2;
    for (int i = 0; i < 4; i++) begin
      if (xfer[i]) begin
        rem[i]--;
        if (rem[i] <= 0) req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input int n);
    req_data[8*i +: 8] = d;
    rem[i] = n;
    req_valid[i] = 1'b1;
  endtask

  task automatic run_until(input int target, input int budget, input string tag);
    int n = 0;
    while (!(frm_byte.size() >= target && !busy) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 32'(frm_byte.size() >= target && !busy), 32'd1);
    repeat (3) tick();
  endtask

  task automatic wait_grant(input int target, input int budget, input string tag);
    int n = 0;
    while (glog.size() < target && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_grant_seen"}, 32'(glog.size() >= target), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fb, gb, bb, rb;
    int exp_b[5];
    int exp_c[3];
    exp_b = '{0, 1, 2, 3, 0};
    exp_c = '{1, 3, 1};
    rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    for (int i = 0; i < 4; i++) begin rem[i] = 0; rdy_cnt[i] = 0; end
    set_req(0, 8'hA5, 1);
    @(posedge clk);
    #2;
    #1;
    check("rst_stx", 32'(stx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);

    // Single byte, granted on the first edge after reset release.
    fb = frm_byte.size(); gb = glog.size(); bb = busy_q.size();
    rst_n = 1'b1;
    #1;
    check("a_ready_first", 32'(req_ready), 32'h1);
    run_until(fb + 1, 200, "a");
    check("a_byte", 32'(frm_at(fb)), 32'hA5);
    check("a_frame_shape", 32'(bad_at(fb)), 32'd0);
    check("a_ready_cycles", 32'(rdy_cnt[0]), 32'd1);
    check("a_busy_len", 32'(busy_at(bb)), 32'(BUSY_LEN));
    check("a_grant_id", 32'(grant_id), 32'd0);
    check("a_glog", 32'(glog_at(gb)), 32'd0);
    check("a_idle_stx", 32'(stx), 32'd1);

    // Fairness with all four requesters pending.
    do_reset();
    fb = frm_byte.size(); gb = glog.size();
    for (int i = 0; i < 4; i++) set_req(i, 8'h10 + 8'(i), (i == 0) ? 2 : 1);
    run_until(fb + 5, 700, "b");
    for (int k = 0; k < 5; k++) begin
      check($sformatf("b_grant%0d", k), 32'(glog_at(gb + k)), 32'(exp_b[k]));
      check($sformatf("b_byte%0d", k), 32'(frm_at(fb + k)), 32'h10 + 32'(exp_b[k]));
      check($sformatf("b_shape%0d", k), 32'(bad_at(fb + k)), 32'd0);
    end
    for (int k = 0; k < 4; k++)
      check($sformatf("b_period%0d", k), 32'(cyc_at(fb + k + 1) - cyc_at(fb + k)), 32'(PERIOD));
    check("b_last_grant_id", 32'(grant_id), 32'd0);

    // Skip and wrap between requesters 1 and 3.
    do_reset();
    fb = frm_byte.size(); gb = glog.size();
    set_req(1, 8'h31, 2);
    set_req(3, 8'h33, 1);
    run_until(fb + 3, 450, "c");
    for (int k = 0; k < 3; k++) begin
      check($sformatf("c_grant%0d", k), 32'(glog_at(gb + k)), 32'(exp_c[k]));
      check($sformatf("c_byte%0d", k), 32'(frm_at(fb + k)), 32'h30 + 32'(exp_c[k]));
    end

    // Reset in the middle of data bit 4, then fresh round from requester 0.
    gb = glog.size();
    set_req(2, 8'h0F, 1);
    wait_grant(gb + 1, 5, "d");
    repeat (55) tick();
    check("d_stx_bit4", 32'(stx), 32'd0);
    check("d_busy_mid", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("d_rst_stx", 32'(stx), 32'd1);
    check("d_rst_busy", 32'(busy), 32'd0);
    check("d_rst_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 4; i++) set_req(i, 8'h40 + 8'(i), 1);
    tick();
    tick();
    fb = frm_byte.size(); gb = glog.size();
    rst_n = 1'b1;
    run_until(fb + 4, 600, "d");
    check("d_first_grant", 32'(glog_at(gb)), 32'd0);
    check("d_first_byte", 32'(frm_at(fb)), 32'h40);
    check("d_frames", 32'(frm_byte.size() - fb), 32'd4);

    // Requester 2 withdraws while another frame is on the line.
    fb = frm_byte.size(); gb = glog.size();
    set_req(0, 8'h55, 1);
    wait_grant(gb + 1, 5, "e");
    repeat (10) tick();
    rb = rdy_cnt[2];
    set_req(2, 8'h77, 1);
    repeat (50) tick();
    req_valid[2] = 1'b0;
    run_until(fb + 1, 200, "e");
    repeat (20) tick();
    check("e_ready2_never", 32'(rdy_cnt[2] - rb), 32'd0);
    check("e_grants", 32'(glog.size() - gb), 32'd1);
    check("e_byte", 32'(frm_at(fb)), 32'h55);
    check("e_frames", 32'(frm_byte.size() - fb), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
